// File: rtl/bot_pkg.sv
// Shared codes for the bot drive FSM and the mission sequencer.
// Drive-state constants and sequencer encodings live here.
package bot_pkg;

    localparam logic [2:0] ST_IDLE       = 3'b000;
    localparam logic [2:0] ST_DRIVE_BOTH = 3'b001;
    localparam logic [2:0] ST_TURN_LEFT  = 3'b010;
    localparam logic [2:0] ST_TURN_RIGHT = 3'b011;
    localparam logic [2:0] ST_U_TURN     = 3'b100;
    localparam logic [2:0] ST_PICK_BOX   = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_RUN    = 2'd2,
        S_RETIRE = 2'd3
    } seq_state_t;

    typedef enum logic [2:0] {
        ACT_NONE     = 3'd0,
        ACT_DONE     = 3'd1,
        ACT_RETRY    = 3'd2,
        ACT_MIS_DROP = 3'd3,
        ACT_TMO_DROP = 3'd4
    } retire_act_t;

    function automatic logic bot_idle(input logic [2:0] s);
        return s == ST_IDLE;
    endfunction

    function automatic logic bot_at_pick(input logic [2:0] s);
        return s == ST_PICK_BOX;
    endfunction

endpackage

// File: rtl/order_fifo.sv
// Synchronous order queue holding RFID tags awaiting dispatch.
// Head is presented combinationally; push and pop may coincide.
module order_fifo #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [TAG_W-1:0]       push_tag,
    input  logic                   pop,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic [TAG_W-1:0]       head
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [TAG_W-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_tag;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mission_sequencer.sv
// Task-level sequencer: queues pick orders, launches the drive FSM,
// verifies the scanned tag and retires, retries or drops each order.
module mission_sequencer
    import bot_pkg::*;
#(
    parameter int TAG_W     = 8,
    parameter int DEPTH     = 4,
    parameter int TIMEOUT   = 1024,
    parameter int MAX_RETRY = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   task_valid,
    input  logic [TAG_W-1:0]       task_tag,
    output logic                   task_ready,
    input  logic [2:0]             bot_state,
    input  logic [TAG_W-1:0]       rfid_tag,
    input  logic                   clr_err,
    output logic                   start_signal,
    output logic                   busy,
    output logic                   done_pulse,
    output logic [TAG_W-1:0]       done_tag,
    output logic                   mismatch_err,
    output logic                   timeout_err,
    output logic [7:0]             tasks_completed,
    output logic [$clog2(DEPTH):0] queue_count
);

    localparam int TW = $clog2(TIMEOUT);
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int TL = TIMEOUT - 1;
    localparam logic [TW-1:0] TMO_LAST  = TL[TW-1:0];
    localparam logic [RW-1:0] RETRY_MAX = MAX_RETRY[RW-1:0];

    seq_state_t       state;
    seq_state_t       state_nx;
    retire_act_t      act;
    logic [TW-1:0]    timer;
    logic [RW-1:0]    retry_cnt;
    logic             match_q;
    logic             tmo_q;
    logic             tmo_hit;
    logic             in_attempt;
    logic             start_d;
    logic             push;
    logic             pop;
    logic             full;
    logic             empty;
    logic [TAG_W-1:0] head;

    order_fifo #(
        .DEPTH (DEPTH),
        .TAG_W (TAG_W)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .push_tag (task_tag),
        .pop      (pop),
        .full     (full),
        .empty    (empty),
        .count    (queue_count),
        .head     (head)
    );

    assign task_ready = !full;
    assign push       = task_valid && !full;
    assign busy       = (state != S_IDLE) || !empty;
    assign in_attempt = (state == S_LAUNCH) || (state == S_RUN);
    assign tmo_hit    = in_attempt && (timer == TMO_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: begin
                if (!empty && bot_idle(bot_state)) begin
                    state_nx = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                if (tmo_hit) begin
                    state_nx = S_RETIRE;
                end else if (!bot_idle(bot_state)) begin
                    state_nx = S_RUN;
                end
            end
            S_RUN: begin
                if (tmo_hit || bot_at_pick(bot_state)) begin
                    state_nx = S_RETIRE;
                end
            end
            S_RETIRE: begin
                if (bot_idle(bot_state)) begin
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // A timed-out attempt is dropped even if a tag was scanned.
    always_comb begin
        act     = ACT_NONE;
        start_d = (state_nx == S_LAUNCH);
        if (state == S_RETIRE && bot_idle(bot_state)) begin
            priority case (1'b1)
                tmo_q:                   act = ACT_TMO_DROP;
                match_q:                 act = ACT_DONE;
                (retry_cnt < RETRY_MAX): act = ACT_RETRY;
                default:                 act = ACT_MIS_DROP;
            endcase
        end
        pop = (act == ACT_DONE) || (act == ACT_MIS_DROP)
           || (act == ACT_TMO_DROP);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timer   <= '0;
            match_q <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            timer <= in_attempt ? timer + 1'b1 : '0;
            if (state == S_IDLE) begin
                match_q <= 1'b0;
                tmo_q   <= 1'b0;
            end else begin
                if (state == S_RUN && bot_at_pick(bot_state)) begin
                    match_q <= (rfid_tag == head);
                end
                if (tmo_hit) begin
                    tmo_q <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            retry_cnt <= '0;
        end else begin
            unique case (act)
                ACT_RETRY:    retry_cnt <= retry_cnt + 1'b1;
                ACT_DONE,
                ACT_MIS_DROP,
                ACT_TMO_DROP: retry_cnt <= '0;
                default:      retry_cnt <= retry_cnt;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            start_signal    <= 1'b0;
            done_pulse      <= 1'b0;
            done_tag        <= '0;
            tasks_completed <= '0;
        end else begin
            start_signal <= start_d;
            done_pulse   <= (act == ACT_DONE);
            if (act == ACT_DONE) begin
                done_tag <= head;
                if (tasks_completed != 8'hFF) begin
                    tasks_completed <= tasks_completed + 8'd1;
                end
            end
        end
    end

    // Setting an error wins over a simultaneous clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mismatch_err <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            if (act == ACT_MIS_DROP) begin
                mismatch_err <= 1'b1;
            end else if (clr_err) begin
                mismatch_err <= 1'b0;
            end
            if (tmo_hit) begin
                timeout_err <= 1'b1;
            end else if (clr_err) begin
                timeout_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mission_sequencer.sv
// Directed and randomized bench for mission_sequencer with a
// queue-based order model; the bench plays the drive FSM.
module tb_mission_sequencer;

    localparam int TAG_W     = 8;
    localparam int DEPTH     = 4;
    localparam int TIMEOUT   = 16;
    localparam int MAX_RETRY = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       task_valid = 1'b0;
    logic [7:0] task_tag = '0;
    logic       task_ready;
    logic [2:0] bot_state = 3'b000;
    logic [7:0] rfid_tag = '0;
    logic       clr_err = 1'b0;
    logic       start_signal;
    logic       busy;
    logic       done_pulse;
    logic [7:0] done_tag;
    logic       mismatch_err;
    logic       timeout_err;
    logic [7:0] tasks_completed;
    logic [2:0] queue_count;

    int checks = 0;
    int failures = 0;

    logic [7:0] mq[$];
    int         m_done = 0;
    logic [7:0] m_last = '0;
    int         m_retry = 0;
    bit         m_mis = 1'b0;

    mission_sequencer #(
        .TAG_W     (TAG_W),
        .DEPTH     (DEPTH),
        .TIMEOUT   (TIMEOUT),
        .MAX_RETRY (MAX_RETRY)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .task_valid      (task_valid),
        .task_tag        (task_tag),
        .task_ready      (task_ready),
        .bot_state       (bot_state),
        .rfid_tag        (rfid_tag),
        .clr_err         (clr_err),
        .start_signal    (start_signal),
        .busy            (busy),
        .done_pulse      (done_pulse),
        .done_tag        (done_tag),
        .mismatch_err    (mismatch_err),
        .timeout_err     (timeout_err),
        .tasks_completed (tasks_completed),
        .queue_count     (queue_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string pfx);
        chk({pfx, "_start"}, start_signal, 0);
        chk({pfx, "_busy"}, busy, 0);
        chk({pfx, "_done_pulse"}, done_pulse, 0);
        chk({pfx, "_done_tag"}, done_tag, 0);
        chk({pfx, "_mis_err"}, mismatch_err, 0);
        chk({pfx, "_tmo_err"}, timeout_err, 0);
        chk({pfx, "_completed"}, tasks_completed, 0);
        chk({pfx, "_qcount"}, queue_count, 0);
        chk({pfx, "_ready"}, task_ready, 1);
    endtask

    task automatic push_tag(input logic [7:0] t);
        int n = 0;
        task_valid = 1'b1;
        task_tag   = t;
        while (!task_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("push_ready", task_ready, 1);
        @(negedge clk);
        task_valid = 1'b0;
        mq.push_back(t);
    endtask

    task automatic wait_start(input string name);
        int n = 0;
        while (!start_signal && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk(name, start_signal, 1);
    endtask

    // One launch of the head order, scanning `scan` at PICK_BOX.
    task automatic attempt(input logic [7:0] scan, input int nrun,
                           input int hold, input bit do_push,
                           input logic [7:0] ptag);
        logic [7:0] head;
        bit         exp_done;
        wait_start("start_seen");
        if (!start_signal) return;
        bot_state = 3'b001;
        @(negedge clk);
        chk("start_drop", start_signal, 0);
        repeat (nrun) @(negedge clk);
        bot_state = 3'b101;
        rfid_tag  = scan;
        @(negedge clk);
        repeat (hold) @(negedge clk);
        bot_state = 3'b000;
        if (do_push) begin
            chk("pushpop_ready", task_ready, 1);
            task_valid = 1'b1;
            task_tag   = ptag;
        end
        @(negedge clk);
        if (do_push) task_valid = 1'b0;
        head     = mq[0];
        exp_done = 1'b0;
        if (scan == head) begin
            void'(mq.pop_front());
            if (m_done < 255) m_done++;
            m_last   = head;
            m_retry  = 0;
            exp_done = 1'b1;
        end else if (m_retry < MAX_RETRY) begin
            m_retry++;
        end else begin
            void'(mq.pop_front());
            m_mis   = 1'b1;
            m_retry = 0;
        end
        if (do_push) mq.push_back(ptag);
        chk("done_pulse", done_pulse, exp_done);
        chk("done_tag", done_tag, m_last);
        chk("tasks_completed", tasks_completed, m_done);
        chk("queue_count", queue_count, mq.size());
        chk("mismatch_err", mismatch_err, m_mis);
    endtask

    initial begin
        logic [7:0] sc;
        repeat (2) @(negedge clk);
        chk_reset_vals("reset");
        reset = 1'b1;
        @(negedge clk);

        // single order
        push_tag(8'h3C);
        chk("single_qcount", queue_count, 1);
        chk("single_busy", busy, 1);
        chk("single_start_early", start_signal, 0);
        @(negedge clk);
        chk("single_start_lat", start_signal, 1);
        attempt(8'h3C, 2, 1, 1'b0, 8'h00);
        @(negedge clk);
        chk("pulse_width", done_pulse, 0);
        chk("single_idle", busy, 0);

        // full queue, fifth order held
        for (int i = 1; i <= 4; i++) push_tag(8'(8'hA0 + i));
        chk("full_qcount", queue_count, 4);
        chk("full_ready", task_ready, 0);
        task_valid = 1'b1;
        task_tag   = 8'hA5;
        repeat (2) @(negedge clk);
        chk("full_hold", queue_count, 4);
        attempt(8'hA1, 1, 0, 1'b0, 8'h00);
        chk("full_ready_after", task_ready, 1);
        @(negedge clk);
        task_valid = 1'b0;
        mq.push_back(8'hA5);
        chk("full_refill", queue_count, 4);
        for (int i = 0; i < 4; i++) attempt(mq[0], 1, 0, 1'b0, 8'h00);

        // push and pop on the same edge
        push_tag(8'hB1);
        push_tag(8'hB2);
        attempt(8'hB1, 1, 0, 1'b1, 8'hB3);
        attempt(8'hB2, 1, 0, 1'b0, 8'h00);
        attempt(8'hB3, 1, 0, 1'b0, 8'h00);
        chk("simul_third", done_tag, 8'hB3);

        // repeated tag mismatch
        push_tag(8'h11);
        for (int i = 0; i < 3; i++) attempt(8'h22, 1, 0, 1'b0, 8'h00);
        repeat (3) @(negedge clk);
        chk("mis_no_relaunch", start_signal, 0);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        m_mis   = 1'b0;
        chk("mis_cleared", mismatch_err, 0);

        // attempt timeout
        push_tag(8'h5A);
        @(negedge clk);
        chk("tmo_start", start_signal, 1);
        bot_state = 3'b001;
        repeat (15) @(negedge clk);
        chk("tmo_before", timeout_err, 0);
        @(negedge clk);
        chk("tmo_set", timeout_err, 1);
        @(negedge clk);
        chk("tmo_held", queue_count, 1);
        bot_state = 3'b000;
        @(negedge clk);
        void'(mq.pop_front());
        m_retry = 0;
        chk("tmo_dropped", queue_count, 0);
        chk("tmo_no_done", done_pulse, 0);
        chk("tmo_completed", tasks_completed, m_done);
        chk("tmo_idle", busy, 0);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        chk("tmo_cleared", timeout_err, 0);

        // randomized traffic
        for (int i = 0; i < 10; i++) begin
            int np;
            np = $urandom_range(1, 2);
            for (int j = 0; j < np; j++) begin
                if (mq.size() < 3) push_tag(8'($urandom));
            end
            if (mq.size() > 0) begin
                sc = ($urandom_range(0, 3) == 0) ? (mq[0] ^ 8'hFF) : mq[0];
                attempt(sc, $urandom_range(0, 4), $urandom_range(0, 2),
                        1'b0, 8'h00);
            end
        end
        for (int k = 0; k < 20 && mq.size() > 0; k++) begin
            attempt(mq[0], 1, 0, 1'b0, 8'h00);
        end

        // reset while running with orders queued
        for (int i = 0; i < 3; i++) push_tag(8'($urandom));
        wait_start("rst_start");
        bot_state = 3'b001;
        repeat (3) @(negedge clk);
        chk("rst_busy_before", busy, 1);
        reset = 1'b0;
        #1;
        chk_reset_vals("midrst");
        bot_state = 3'b000;
        @(negedge clk);
        reset = 1'b1;
        mq.delete();
        m_done  = 0;
        m_last  = '0;
        m_retry = 0;
        m_mis   = 1'b0;
        push_tag(8'h77);
        attempt(8'h77, 1, 0, 1'b0, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
